// File: rtl/adder_16.sv
// adder_16: 16-bit ripple-carry adder with carry-in, carry-out and signed
// overflow. The combinational core is a plain chain of one-bit full-adder
// stages. Only sum, cout and ovf are registered.

// One-bit full-adder stage used as the building block of the ripple chain.
module full_adder (
   input  logic a,
   input  logic b,
   input  logic ci,
   output logic s,
   output logic co
);

   logic p;

   // Propagate term, shared by the sum bit and the carry bit.
   assign p  = a ^ b;
   assign s  = p ^ ci;
   assign co = (a & b) | (ci & p);

endmodule

module adder_16 #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   // carry[i] is the carry into stage i; carry[WIDTH] is the carry out.
   logic [WIDTH:0]   carry;
   logic [WIDTH-1:0] sumComb;
   logic             ovfComb;

   assign carry[0] = cin;

   // Each stage waits on the carry from the stage below it.
   // There is no lookahead or carry-select, so carry[WIDTH] is the critical path.
   for (genvar i = 0; i < WIDTH; i++) begin : g_stage
      full_adder u_fa (
         .a  (a[i]),
         .b  (b[i]),
         .ci (carry[i]),
         .s  (sumComb[i]),
         .co (carry[i+1])
      );
   end

   // Signed overflow happens when the carry into the sign bit differs from
   // the carry out of it. This matches "same operand signs, different
   // result sign".
   assign ovfComb = carry[WIDTH] ^ carry[WIDTH-1];

   // Output register. A synchronous reset discards the operands present at
   // that edge, so nothing from them reaches the outputs later.
   always_ff @(posedge clk) begin
      if (rst) begin
         sum  <= '0;
         cout <= 1'b0;
         ovf  <= 1'b0;
      end else begin
         sum  <= sumComb;
         cout <= carry[WIDTH];
         ovf  <= ovfComb;
      end
   end

endmodule

// File: tb/tb_adder_16.sv
// tb_adder_16: directed-vector bench for adder_16, followed by a random sweep
// that is checked against a 17-bit arithmetic model.

module tb_adder_16;

   logic        clk;
   logic        rst;
   logic [15:0] a;
   logic [15:0] b;
   logic        cin;
   logic [15:0] sum;
   logic        cout;
   logic        ovf;

   int compared   = 0;
   int mismatched = 0;

   adder_16 dut (
      .clk  (clk),
      .rst  (rst),
      .a    (a),
      .b    (b),
      .cin  (cin),
      .sum  (sum),
      .cout (cout),
      .ovf  (ovf)
   );

   // Free-running clock with a 10-unit period.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drive one set of inputs, then wait for the next rising edge and settle
   // 1 unit past it before any check.
   task automatic applyStimulus(input logic r, input logic [15:0] av,
                                input logic [15:0] bv, input logic c);
      rst = r;
      a   = av;
      b   = bv;
      cin = c;
      @(posedge clk);
      #1;
   endtask

   // Compare the registered outputs against the expected values.
   task automatic checkOutput(input string tag, input logic [15:0] eSum,
                              input logic eCout, input logic eOvf);
      compared++;
      assert (sum === eSum) else begin
         mismatched++;
         $error("[TB] FAIL %s sum: observed %h expected %h", tag, sum, eSum);
      end
      compared++;
      assert (cout === eCout) else begin
         mismatched++;
         $error("[TB] FAIL %s cout: observed %b expected %b", tag, cout, eCout);
      end
      compared++;
      assert (ovf === eOvf) else begin
         mismatched++;
         $error("[TB] FAIL %s ovf: observed %b expected %b", tag, ovf, eOvf);
      end
   endtask

   // Directed steps, then the random sweep and the summary line.
   initial begin
      logic [16:0] full;
      logic [15:0] ra, rb;
      logic        rc;
      logic        eo;

      // Hold reset for two edges while the operands are all ones.
      applyStimulus(1'b1, 16'hFFFF, 16'hFFFF, 1'b1);
      checkOutput("reset1", 16'h0000, 1'b0, 1'b0);
      applyStimulus(1'b1, 16'hFFFF, 16'hFFFF, 1'b1);
      checkOutput("reset2", 16'h0000, 1'b0, 1'b0);
      applyStimulus(1'b0, 16'hFFFF, 16'hFFFF, 1'b1);
      checkOutput("afterReset", 16'hFFFF, 1'b1, 1'b0);

      // Back-to-back operand sets, one result per cycle.
      applyStimulus(1'b0, 16'hFF00, 16'h00FF, 1'b0);
      checkOutput("noCarryFill", 16'hFFFF, 1'b0, 1'b0);
      applyStimulus(1'b0, 16'hFF00, 16'h00FF, 1'b1);
      checkOutput("fullRipple", 16'h0000, 1'b1, 1'b0);
      applyStimulus(1'b0, 16'h03C3, 16'h00CF, 1'b1);
      checkOutput("mixed", 16'h0493, 1'b0, 1'b0);
      applyStimulus(1'b0, 16'h7FFF, 16'h0001, 1'b0);
      checkOutput("posOverflow", 16'h8000, 1'b0, 1'b1);
      applyStimulus(1'b0, 16'h8000, 16'h8000, 1'b0);
      checkOutput("negOverflow", 16'h0000, 1'b1, 1'b1);
      applyStimulus(1'b0, 16'hFFFF, 16'h0001, 1'b0);
      checkOutput("minusOnePlusOne", 16'h0000, 1'b1, 1'b0);
      applyStimulus(1'b0, 16'h8000, 16'hFFFF, 1'b0);
      checkOutput("minPlusMinusOne", 16'h7FFF, 1'b1, 1'b1);
      applyStimulus(1'b0, 16'h1234, 16'h4321, 1'b0);
      checkOutput("plain", 16'h5555, 1'b0, 1'b0);

      // Changing the inputs between edges must not disturb the outputs.
      a   = 16'hFFFF;
      b   = 16'hFFFF;
      cin = 1'b1;
      #3;
      checkOutput("holdBetweenEdges", 16'h5555, 1'b0, 1'b0);

      // Reset in the middle of a run drops the operands present at that edge.
      applyStimulus(1'b1, 16'h7FFF, 16'h7FFF, 1'b1);
      checkOutput("midReset", 16'h0000, 1'b0, 1'b0);
      applyStimulus(1'b0, 16'h0001, 16'h0002, 1'b1);
      checkOutput("firstAfterMidReset", 16'h0004, 1'b0, 1'b0);
      applyStimulus(1'b0, 16'h0000, 16'h0000, 1'b0);
      checkOutput("zero", 16'h0000, 1'b0, 1'b0);

      // Random sweep against the 17-bit sum and the sign-based overflow rule.
      for (int i = 0; i < 10000; i++) begin
         ra   = 16'($urandom);
         rb   = 16'($urandom);
         rc   = 1'($urandom);
         full = {1'b0, ra} + {1'b0, rb} + {16'b0, rc};
         eo   = (ra[15] == rb[15]) && (full[15] != ra[15]);
         applyStimulus(1'b0, ra, rb, rc);
         checkOutput("random", full[15:0], full[16], eo);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/adder_16.md
# adder_16

16-bit ripple-carry adder with carry-in, carry-out and signed-overflow flag, and a single registered output stage. It is the baseline adder of the arithmetic lab set and the reference point against which the faster adder variants are compared. The combinational core is an explicit chain of 16 one-bit full-adder stages. Only the results are registered, on the single clock.

## Interface
- WIDTH, 16, operand and sum width; the block is specified and verified at 16 only.
- clk  input  1  rising-edge clock for the output register.
- rst  input  1  synchronous, active-high reset; clears all outputs.
- a  input  16  first operand, unsigned or two's complement.
- b  input  16  second operand, unsigned or two's complement.
- cin  input  1  carry into bit 0.
- sum  output  16  registered result, (a + b + cin) mod 2^16.
- cout  output  1  registered carry out of bit 15.
- ovf  output  1  registered signed overflow, two's-complement interpretation.

## Operation
- Core: 16 cascaded full-adder stages; stage i takes a[i], b[i], c[i].
  - c[0] = cin.
  - s[i] = a[i] ^ b[i] ^ c[i].
  - c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i])).
- Carry ripples strictly stage to stage. No lookahead, no carry-select.
- Full-adder stage is a separate submodule instantiated 16 times (generate loop or explicit instances).
- Arithmetic result: 17 bits, {cout, sum} = a + b + cin, all operands zero-extended.
- ovf = (a[15] == b[15]) & (s[15] != a[15]); equivalently c[16] ^ c[15]. Both forms must agree.
- No saturation, no wrap detection beyond cout and ovf; sum always wraps modulo 2^16.
- Inputs are unregistered; only sum, cout and ovf are registered.
- No X-propagation handling required: X on any input may yield X outputs.

## Timing
- Latency: 1 cycle. Inputs stable before rising edge k give a result visible after edge k.
- Throughput: one new addition per cycle; back-to-back operands need no idle cycles.
- Reset: rst sampled high at a rising edge forces sum = 16'h0000, cout = 0, ovf = 0 after that edge.
- rst has priority over the computed result.
- Reset values hold for every edge at which rst is high.
- Reset mid-operation: operands present at an edge where rst is high are discarded, not delayed.
- The first valid result after reset comes from operands at the first edge with rst low.
- Outputs hold their value between edges regardless of input changes (no combinational path to outputs).
- Critical path: the full 16-stage carry ripple from a[0]/b[0]/cin to c[16]/s[15]. The block must meet one clock period including this path.

## Test plan
- Reset: rst=1 for 2 cycles with a=16'hFFFF, b=16'hFFFF, cin=1 -> sum=16'h0000, cout=0, ovf=0. Release rst -> next edge sum=16'hFFFF, cout=1, ovf=0.
- No-carry fill: a=16'hFF00, b=16'h00FF, cin=0 -> sum=16'hFFFF, cout=0, ovf=0.
- Full ripple: a=16'hFF00, b=16'h00FF, cin=1 -> sum=16'h0000, cout=1, ovf=0. This is the carry propagating through all 16 stages.
- Mixed: a=16'h03C3, b=16'h00CF, cin=1 -> sum=16'h0493, cout=0, ovf=0.
- Overflow cases:
  - a=16'h7FFF, b=16'h0001, cin=0 -> sum=16'h8000, cout=0, ovf=1.
  - a=16'h8000, b=16'h8000, cin=0 -> sum=16'h0000, cout=1, ovf=1.
- Back-to-back and random:
  - Apply the four operand sets above on consecutive cycles -> each result appears exactly one cycle later, in order.
  - 10k random (a, b, cin) compared against the 17-bit model a+b+cin plus the ovf formula.
